// File: rtl/wishbone_sram_responder_pkg.sv
// Shared Wishbone types for the SRAM responder: cycle-type/burst encodings,
// responder FSM states and the address-window helper.
package wishbone_types;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } wb_cti_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } wb_bte_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    ACK,
    ERR
  } wb_resp_state_t;

  localparam int unsigned WAIT_STATES_MAX = 15;

  // Offset is the word distance from the window base; wraps to huge values below it.
  function automatic logic word_in_window(input logic [29:0] offset, input int unsigned depth);
    return offset < 30'(depth);
  endfunction

endpackage

// File: rtl/wishbone_sram_responder_if.sv
// Wishbone classic-cycle bus bundle between one master and the SRAM responder.
interface wishbone_sram_responder_if;
  import wishbone_types::*;

  // Handshake: a request is live while cyc & stb; the slave terminates it with
  // exactly one cycle of ack or err (never both); dat_r is meaningful only with ack.
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  wb_cti_t     cti;
  wb_bte_t     bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, stb, cyc, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc, cti, bte,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wishbone_sram_responder_sram.sv
// Single-port DEPTH_WORDS x 32 SRAM with per-byte write enables and a
// registered, read-before-write output.
module wb_byte_en_sram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     be,
  input  logic [31:0]                    data_in,
  output logic [31:0]                    data_out
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      data_out <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/wishbone_sram_responder.sv
// Wishbone classic slave fronting a byte-enabled scratchpad SRAM, with
// programmable wait states and err termination outside the address window.
module wishbone_sram_responder
  import wishbone_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  wishbone_sram_responder_if.slave  bus,
  output wb_resp_state_t            state_dbg
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  wb_resp_state_t state, state_next;
  logic [3:0]     cnt_q, cnt_next;
  logic [AW-1:0]  idx_q;
  logic [31:0]    dat_q;
  logic [3:0]     sel_q;
  logic           we_q;
  logic           capture;

  logic [29:0]    offset;
  logic           in_range;

  logic           sram_en;
  logic [3:0]     sram_be;
  logic [31:0]    sram_q;

  logic           ack_c;
  logic           err_c;
  logic [31:0]    dat_r_c;

  logic           unused_ok;

  assign offset   = bus.adr[31:2] - BASE_ADDR[31:2];
  assign in_range = word_in_window(offset, DEPTH_WORDS);

  assign unused_ok = ^{bus.cti, bus.bte, bus.adr[1:0], offset};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
      if (capture) begin
        idx_q <= offset[AW-1:0];
        dat_q <= bus.dat_w;
        sel_q <= bus.sel;
        we_q  <= bus.we;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    capture    = 1'b0;
    sram_en    = 1'b0;
    sram_be    = '0;
    ack_c      = 1'b0;
    err_c      = 1'b0;
    dat_r_c    = '0;
    case (state)
      IDLE: begin
        if (bus.cyc && bus.stb) begin
          capture = 1'b1;
          if (!in_range) begin
            state_next = ERR;
          end else if (WS == 4'd0) begin
            state_next = ACCESS;
          end else begin
            state_next = WAIT;
            cnt_next   = WS;
          end
        end
      end
      WAIT: begin
        if (!bus.cyc) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        sram_en = 1'b1;
        if (!bus.cyc) begin
          state_next = IDLE;
        end else begin
          if (we_q) begin
            sram_be = sel_q;
          end
          state_next = ACK;
        end
      end
      ACK: begin
        ack_c      = 1'b1;
        dat_r_c    = sram_q;
        state_next = IDLE;
      end
      ERR: begin
        err_c      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A reset landing on ACCESS must drop the write; terminations are suppressed too.
    if (rst) begin
      sram_be = '0;
      ack_c   = 1'b0;
      err_c   = 1'b0;
      dat_r_c = '0;
    end
  end

  wb_byte_en_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk      (clk),
    .en       (sram_en),
    .addr     (idx_q),
    .be       (sram_be),
    .data_in  (dat_q),
    .data_out (sram_q)
  );

  assign bus.ack   = ack_c;
  assign bus.err   = err_c;
  assign bus.dat_r = dat_r_c;
  assign state_dbg = state;

endmodule

// File: tb/tb_wishbone_sram_responder.sv
// Bench for wishbone_sram_responder: two instances (1 and 3 wait states) share
// one driver; an expected-response queue is checked by an independent monitor.
module tb_wishbone_sram_responder;
  import wishbone_types::*;

  localparam logic [1:0] K_RD  = 2'b01;
  localparam logic [1:0] K_ERR = 2'b10;
  localparam logic [1:0] K_WR  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  int          dsel;

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];

  wishbone_sram_responder_if bus0 ();
  wishbone_sram_responder_if bus1 ();
  wb_resp_state_t st0, st1;

  assign bus0.adr   = adr;
  assign bus0.dat_w = dat_w;
  assign bus0.sel   = sel;
  assign bus0.we    = we;
  assign bus0.stb   = stb && (dsel == 0);
  assign bus0.cyc   = cyc && (dsel == 0);
  assign bus0.cti   = CTI_CLASSIC;
  assign bus0.bte   = BTE_LINEAR;

  assign bus1.adr   = adr;
  assign bus1.dat_w = dat_w;
  assign bus1.sel   = sel;
  assign bus1.we    = we;
  assign bus1.stb   = stb && (dsel == 1);
  assign bus1.cyc   = cyc && (dsel == 1);
  assign bus1.cti   = CTI_CLASSIC;
  assign bus1.bte   = BTE_LINEAR;

  wishbone_sram_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(1)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0)
  );

  wishbone_sram_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every termination on either bus consumes one expected entry.
  task automatic mon(input string who, input logic a, input logic e, input logic [31:0] d);
    logic [33:0] ent;
    logic        ok;
    if (a || e) begin
      tests++;
      if (a && e) begin
        fails++;
        $display("FAIL %s_ack_err_both: got ack=1 err=1, expected one of them", who);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s_unexpected: got ack=%b err=%b dat=%h, expected no response", who, a, e, d);
      end else begin
        ent = exp_q.pop_front();
        case (ent[33:32])
          K_ERR:   ok = e && !a && (d == 32'h0);
          K_RD:    ok = a && !e && (d == ent[31:0]);
          default: ok = a && !e;
        endcase
        if (!ok) begin
          fails++;
          $display("FAIL %s_resp: got ack=%b err=%b dat=%h, expected kind=%0d dat=%h",
                   who, a, e, d, ent[33:32], ent[31:0]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon("dut0", bus0.ack, bus0.err, bus0.dat_r);
      mon("dut1", bus1.ack, bus1.err, bus1.dat_r);
    end
  end

  // Called at posedge+#1; returns at posedge+#1 with stb low, so calls chain back-to-back.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input logic [1:0] kind,
                      input logic [31:0] exp_d, input int exp_lat, input logic hold);
    int   n;
    logic seen;
    adr = a; we = w; sel = s; dat_w = d; cyc = 1'b1; stb = 1'b1;
    exp_q.push_back({kind, exp_d});
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (dsel == 0) seen = bus0.ack || bus0.err;
      else           seen = bus1.ack || bus1.err;
      if (!seen) n++;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL latency_timeout @%h: got no termination in 40 cycles, expected %0d", a, exp_lat);
    end else if (n != exp_lat) begin
      fails++;
      $display("FAIL latency @%h: got %0d, expected %0d", a, n, exp_lat);
    end
    @(posedge clk); #1;
    stb = 1'b0;
    cyc = hold;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ack0"}, {31'd0, bus0.ack}, 32'd0);
    check({name, "_err0"}, {31'd0, bus0.err}, 32'd0);
    check({name, "_dat0"}, bus0.dat_r, 32'd0);
    check({name, "_ack1"}, {31'd0, bus1.ack}, 32'd0);
    check({name, "_err1"}, {31'd0, bus1.err}, 32'd0);
    check({name, "_dat1"}, bus1.dat_r, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; dsel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset_state0", 32'(st0), 32'(IDLE));
    check("reset_state1", 32'(st1), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // One wait state: full-word write then back-to-back read of the same word.
    xfer(32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, K_WR, 32'h0, 3, 1'b0);
    xfer(32'h8000_0010, 1'b0, 4'h0, 32'h0, K_RD, 32'hDEAD_BEEF, 3, 1'b0);

    // Single-lane merge.
    xfer(32'h8000_0020, 1'b1, 4'hF, 32'h1122_3344, K_WR, 32'h0, 3, 1'b0);
    xfer(32'h8000_0020, 1'b1, 4'b0010, 32'h0000_AB00, K_WR, 32'h0, 3, 1'b0);
    xfer(32'h8000_0020, 1'b0, 4'hF, 32'h0, K_RD, 32'h1122_AB44, 3, 1'b0);

    // Last word of the window; low address bits ignored.
    xfer(32'h8000_0FFC, 1'b1, 4'hF, 32'hA5A5_0FFC, K_WR, 32'h0, 3, 1'b0);
    xfer(32'h8000_0FFD, 1'b0, 4'h1, 32'h0, K_RD, 32'hA5A5_0FFC, 3, 1'b0);

    // Out-of-window: err after one cycle, and an errored write leaves word 0 alone.
    xfer(32'h8000_0000, 1'b1, 4'hF, 32'h0000_0001, K_WR, 32'h0, 3, 1'b0);
    xfer(32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0, K_ERR, 32'h0, 1, 1'b0);
    xfer(32'h8000_1000, 1'b0, 4'hF, 32'h0, K_ERR, 32'h0, 1, 1'b0);
    xfer(32'h8000_1000, 1'b1, 4'hF, 32'hFFFF_FFFF, K_ERR, 32'h0, 1, 1'b0);
    xfer(32'h8000_0000, 1'b0, 4'hF, 32'h0, K_RD, 32'h0000_0001, 3, 1'b0);

    // LR hold: cyc stays up with stb low, then an AMO pair under the same cycle.
    xfer(32'h8000_0030, 1'b1, 4'hF, 32'd5, K_WR, 32'h0, 3, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("lr_hold_quiet", {30'd0, bus0.ack, bus0.err}, 32'd0);
    end
    @(posedge clk); #1;
    xfer(32'h8000_0030, 1'b0, 4'hF, 32'h0, K_RD, 32'd5, 3, 1'b1);
    xfer(32'h8000_0030, 1'b1, 4'hF, 32'd9, K_WR, 32'h0, 3, 1'b1);
    xfer(32'h8000_0030, 1'b0, 4'hF, 32'h0, K_RD, 32'd9, 3, 1'b0);

    // Three wait states: abort by dropping cyc two cycles after the strobe.
    @(posedge clk); #1;
    dsel = 1;
    xfer(32'h8000_0040, 1'b1, 4'hF, 32'h0BAD_F00D, K_WR, 32'h0, 5, 1'b0);
    xfer(32'h9000_0000, 1'b0, 4'hF, 32'h0, K_ERR, 32'h0, 1, 1'b0);
    adr = 32'h8000_0040; we = 1'b1; sel = 4'hF; dat_w = 32'h1234_5678; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_state1", 32'(st1), 32'(IDLE));
    xfer(32'h8000_0040, 1'b0, 4'hF, 32'h0, K_RD, 32'h0BAD_F00D, 5, 1'b0);

    // Reset while the request sits in WAIT.
    xfer(32'h8000_0050, 1'b1, 4'hF, 32'hCAFE_F00D, K_WR, 32'h0, 5, 1'b0);
    adr = 32'h8000_0050; we = 1'b1; sel = 4'hF; dat_w = 32'h1111_1111; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_state1", 32'(st1), 32'(WAIT));
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk);
    @(negedge clk);
    check_quiet("mid_reset_b");
    check("mid_reset_state1", 32'(st1), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    xfer(32'h8000_0050, 1'b0, 4'hF, 32'h0, K_RD, 32'hCAFE_F00D, 5, 1'b0);

    repeat (8) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
